mapper_uxrom_flash: RTL and testbench

MAPPER_UXROM_FLASH -- requirements
Module: mapper_uxrom_flash

---
 rtl/mapper_uxrom_flash_pkg.sv | 41 ++++
 rtl/mapper_uxrom_flash_cmd_decoder.sv | 101 ++++++++++
 rtl/mapper_uxrom_flash.sv | 92 +++++++++
 tb/tb_mapper_uxrom_flash.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mapper_uxrom_flash_pkg.sv
// Shared constants for the UxROM flash mapper: nametable layout codes,
// flash command addresses/bytes and the command decoder state type.
package mapper_uxrom_flash_pkg;

  localparam logic [2:0] NAMETABLE_LAYOUT_HORIZONTAL          = 3'd0;
  localparam logic [2:0] NAMETABLE_LAYOUT_VERTICAL            = 3'd1;
  localparam logic [2:0] NAMETABLE_LAYOUT_SINGLE_SCREEN_LOWER = 3'd2;
  localparam logic [2:0] NAMETABLE_LAYOUT_SINGLE_SCREEN_UPPER = 3'd3;
  localparam logic [2:0] NAMETABLE_LAYOUT_FOUR_SCREEN         = 3'd4;

  localparam logic [14:0] FLASH_CMD_ADDR_5555 = 15'h5555;
  localparam logic [14:0] FLASH_CMD_ADDR_2AAA = 15'h2AAA;

  localparam logic [7:0] FLASH_CMD_UNLOCK1     = 8'hAA;
  localparam logic [7:0] FLASH_CMD_UNLOCK2     = 8'h55;
  localparam logic [7:0] FLASH_CMD_PROGRAM     = 8'hA0;
  localparam logic [7:0] FLASH_CMD_ERASE       = 8'h80;
  localparam logic [7:0] FLASH_CMD_SECTOR      = 8'h30;
  localparam logic [7:0] FLASH_CMD_RESET       = 8'hF0;

  typedef enum logic [2:0] {
    FLASH_IDLE,
    FLASH_C1,
    FLASH_C2,
    FLASH_PROG,
    FLASH_E3,
    FLASH_E4,
    FLASH_E5,
    FLASH_BUSY
  } flash_state_t;

  // CHR bank bits above CHR_BANK_BITS are forced to zero at latch time.
  function automatic logic [1:0] chr_bank_mask(input logic [1:0] v, input int unsigned bits);
    case (bits)
      0:       return 2'b00;
      1:       return {1'b0, v[0]};
      default: return v;
    endcase
  endfunction

endpackage

// File: rtl/mapper_uxrom_flash_cmd_decoder.sv
// JEDEC-style flash command sequencer: unlock/program/sector-erase
// detection, one-cycle command pulses and a fixed-length busy window.
module flash_cmd_decoder
  import mapper_uxrom_flash_pkg::*;
#(
  parameter int unsigned PROG_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wr_i,
  input  logic [7:0]  wr_data_i,
  input  logic [18:0] fa_i,
  output logic        prog_o,
  output logic        erase_o,
  output logic [18:0] addr_o,
  output logic [7:0]  data_o,
  output logic        busy_o
);

  localparam int unsigned CNT_W = (PROG_CYCLES > 1) ? $clog2(PROG_CYCLES) : 1;

  flash_state_t      state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              prog_n, erase_n;
  logic [18:0]       addr_n;
  logic [7:0]        data_n;
  logic              at_5555, at_2aaa;

  assign at_5555 = (fa_i[14:0] == FLASH_CMD_ADDR_5555);
  assign at_2aaa = (fa_i[14:0] == FLASH_CMD_ADDR_2AAA);
  assign busy_o  = (state == FLASH_BUSY);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= FLASH_IDLE;
      cnt     <= '0;
      prog_o  <= 1'b0;
      erase_o <= 1'b0;
      addr_o  <= '0;
      data_o  <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      prog_o  <= prog_n;
      erase_o <= erase_n;
      addr_o  <= addr_n;
      data_o  <= data_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    prog_n  = 1'b0;
    erase_n = 1'b0;
    addr_n  = addr_o;
    data_n  = data_o;
    if (state == FLASH_BUSY) begin
      // The pulse cycle is the first busy cycle, so the count starts at N-1.
      if (cnt == '0) state_n = FLASH_IDLE;
      else           cnt_n   = cnt - 1'b1;
    end else if (wr_i) begin
      if (wr_data_i == FLASH_CMD_RESET) begin
        state_n = FLASH_IDLE;
      end else begin
        case (state)
          FLASH_IDLE:
            if (at_5555 && wr_data_i == FLASH_CMD_UNLOCK1) state_n = FLASH_C1;
          FLASH_C1:
            state_n = (at_2aaa && wr_data_i == FLASH_CMD_UNLOCK2) ? FLASH_C2 : FLASH_IDLE;
          FLASH_C2:
            if (at_5555 && wr_data_i == FLASH_CMD_PROGRAM)    state_n = FLASH_PROG;
            else if (at_5555 && wr_data_i == FLASH_CMD_ERASE) state_n = FLASH_E3;
            else                                              state_n = FLASH_IDLE;
          FLASH_PROG: begin
            prog_n  = 1'b1;
            addr_n  = fa_i;
            data_n  = wr_data_i;
            cnt_n   = CNT_W'(PROG_CYCLES - 1);
            state_n = FLASH_BUSY;
          end
          FLASH_E3:
            state_n = (at_5555 && wr_data_i == FLASH_CMD_UNLOCK1) ? FLASH_E4 : FLASH_IDLE;
          FLASH_E4:
            state_n = (at_2aaa && wr_data_i == FLASH_CMD_UNLOCK2) ? FLASH_E5 : FLASH_IDLE;
          FLASH_E5:
            if (wr_data_i == FLASH_CMD_SECTOR) begin
              erase_n = 1'b1;
              addr_n  = {fa_i[18:12], 12'h000};
              cnt_n   = CNT_W'(PROG_CYCLES - 1);
              state_n = FLASH_BUSY;
            end else begin
              state_n = FLASH_IDLE;
            end
          default: state_n = FLASH_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/mapper_uxrom_flash.sv
// UxROM mapper with self-flashable PRG: bank register, PRG/CHR/RAM address
// extension, nametable layout select and the flash command decoder.
module mapper_uxrom_flash
  import mapper_uxrom_flash_pkg::*;
#(
  parameter int unsigned PRG_BANK_BITS    = 5,
  parameter int unsigned CHR_BANK_BITS    = 2,
  parameter bit          FIXED_BANK_FIRST = 1'b0,
  parameter bit          BUS_CONFLICTS    = 1'b0,
  parameter bit          FLASH_EN         = 1'b1,
  parameter int unsigned PROG_CYCLES      = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mapper_wr_i,
  input  logic [7:0]  mapper_wr_data_i,
  input  logic [14:0] prg_rom_addr_i,
  input  logic [7:0]  prg_rom_rd_data_i,
  input  logic [12:0] prg_ram_addr_i,
  input  logic [12:0] chr_mem_addr_i,
  input  logic        hw_nametable_layout_i,
  input  logic        hw_one_screen_i,
  output logic [18:0] prg_rom_addr_o,
  output logic [14:0] prg_ram_addr_o,
  output logic [17:0] chr_mem_addr_o,
  output logic [2:0]  nametable_layout_o,
  output logic        flash_prog_o,
  output logic        flash_erase_o,
  output logic [18:0] flash_addr_o,
  output logic [7:0]  flash_data_o,
  output logic        flash_busy_o
);

  logic [PRG_BANK_BITS-1:0] prg_bank, prg_sel;
  logic [1:0]               chr_bank;
  logic                     ntsel;
  logic [7:0]               wr_val;
  logic                     bank_wr, flash_wr;
  logic [18:0]              fa;

  assign bank_wr  = mapper_wr_i && (!FLASH_EN || prg_rom_addr_i[14]);
  assign flash_wr = FLASH_EN && mapper_wr_i && !prg_rom_addr_i[14];
  assign wr_val   = BUS_CONFLICTS ? (mapper_wr_data_i & prg_rom_rd_data_i) : mapper_wr_data_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prg_bank <= '0;
      chr_bank <= '0;
      ntsel    <= 1'b0;
    end else if (bank_wr) begin
      prg_bank <= wr_val[PRG_BANK_BITS-1:0];
      chr_bank <= chr_bank_mask(wr_val[6:5], CHR_BANK_BITS);
      ntsel    <= wr_val[7];
    end
  end

  always_comb begin
    if (FIXED_BANK_FIRST) prg_sel = prg_rom_addr_i[14] ? prg_bank : '0;
    else                  prg_sel = prg_rom_addr_i[14] ? '1 : prg_bank;
  end

  assign prg_rom_addr_o = 19'({prg_sel, prg_rom_addr_i[13:0]});
  assign chr_mem_addr_o = 18'({chr_bank, chr_mem_addr_i});
  assign prg_ram_addr_o = {2'b00, prg_ram_addr_i};
  // Flash target always uses the switchable bank, even in the fixed window.
  assign fa             = 19'({prg_bank, prg_rom_addr_i[13:0]});

  always_comb begin
    nametable_layout_o = NAMETABLE_LAYOUT_HORIZONTAL;
    if (hw_one_screen_i)
      nametable_layout_o = ntsel ? NAMETABLE_LAYOUT_SINGLE_SCREEN_UPPER
                                 : NAMETABLE_LAYOUT_SINGLE_SCREEN_LOWER;
    else if (hw_nametable_layout_i)
      nametable_layout_o = NAMETABLE_LAYOUT_VERTICAL;
  end

  flash_cmd_decoder #(
    .PROG_CYCLES(PROG_CYCLES)
  ) u_flash_cmd_decoder (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .wr_i     (flash_wr),
    .wr_data_i(mapper_wr_data_i),
    .fa_i     (fa),
    .prog_o   (flash_prog_o),
    .erase_o  (flash_erase_o),
    .addr_o   (flash_addr_o),
    .data_o   (flash_data_o),
    .busy_o   (flash_busy_o)
  );

endmodule

// File: tb/tb_mapper_uxrom_flash.sv
// Directed plus randomized checks of the UxROM flash mapper against a
// behavioural model of banking, layout and flash command timing.
module tb_mapper_uxrom_flash;
  import mapper_uxrom_flash_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr = 1'b0;
  logic [7:0]  wdata = '0;
  logic [14:0] a = '0;
  logic [7:0]  rd = 8'hFF;
  logic [12:0] ram = '0;
  logic [12:0] chr = '0;
  logic        hw_layout = 1'b1;
  logic        hw_one = 1'b0;

  logic [18:0] o0_prg, o1_prg, o0_faddr, o1_faddr;
  logic [14:0] o0_ram, o1_ram;
  logic [17:0] o0_chr, o1_chr;
  logic [2:0]  o0_nt, o1_nt;
  logic        o0_prog, o1_prog, o0_erase, o1_erase, o0_busy, o1_busy;
  logic [7:0]  o0_fdata, o1_fdata;

  int checks = 0;
  int failures = 0;
  int prog_seen = 0;
  int erase_seen = 0;
  int m0_bank, m0_chr, m0_nt, m1_bank, m1_chr, m1_nt;

  always #5 clk = ~clk;

  mapper_uxrom_flash dut0 (
    .clk_i(clk), .rst_i(rst), .mapper_wr_i(wr), .mapper_wr_data_i(wdata),
    .prg_rom_addr_i(a), .prg_rom_rd_data_i(rd), .prg_ram_addr_i(ram),
    .chr_mem_addr_i(chr), .hw_nametable_layout_i(hw_layout), .hw_one_screen_i(hw_one),
    .prg_rom_addr_o(o0_prg), .prg_ram_addr_o(o0_ram), .chr_mem_addr_o(o0_chr),
    .nametable_layout_o(o0_nt), .flash_prog_o(o0_prog), .flash_erase_o(o0_erase),
    .flash_addr_o(o0_faddr), .flash_data_o(o0_fdata), .flash_busy_o(o0_busy)
  );

  mapper_uxrom_flash #(.BUS_CONFLICTS(1'b1), .FIXED_BANK_FIRST(1'b1)) dut1 (
    .clk_i(clk), .rst_i(rst), .mapper_wr_i(wr), .mapper_wr_data_i(wdata),
    .prg_rom_addr_i(a), .prg_rom_rd_data_i(rd), .prg_ram_addr_i(ram),
    .chr_mem_addr_i(chr), .hw_nametable_layout_i(hw_layout), .hw_one_screen_i(hw_one),
    .prg_rom_addr_o(o1_prg), .prg_ram_addr_o(o1_ram), .chr_mem_addr_o(o1_chr),
    .nametable_layout_o(o1_nt), .flash_prog_o(o1_prog), .flash_erase_o(o1_erase),
    .flash_addr_o(o1_faddr), .flash_data_o(o1_fdata), .flash_busy_o(o1_busy)
  );

  always @(negedge clk) begin
    if (o0_prog)  prog_seen++;
    if (o0_erase) erase_seen++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_prg(input int fixed_first, input int bank, input int addr);
    int hi, sel;
    hi = (addr / 16384) % 2;
    if (fixed_first == 0) sel = hi ? 31 : bank;
    else                  sel = hi ? bank : 0;
    return sel * 16384 + addr % 16384;
  endfunction

  function automatic logic [2:0] exp_nt(input int nt, input logic one, input logic lay);
    if (one) return nt ? NAMETABLE_LAYOUT_SINGLE_SCREEN_UPPER : NAMETABLE_LAYOUT_SINGLE_SCREEN_LOWER;
    return lay ? NAMETABLE_LAYOUT_VERTICAL : NAMETABLE_LAYOUT_HORIZONTAL;
  endfunction

  task automatic model_write(input int d, input int r);
    int v;
    m0_bank = d % 32; m0_chr = (d / 32) % 4; m0_nt = d / 128;
    v = d & r;
    m1_bank = v % 32; m1_chr = (v / 32) % 4; m1_nt = v / 128;
  endtask

  task automatic model_reset();
    m0_bank = 0; m0_chr = 0; m0_nt = 0;
    m1_bank = 0; m1_chr = 0; m1_nt = 0;
  endtask

  task automatic wr_cycle(input logic [14:0] addr, input logic [7:0] d);
    a = addr; wdata = d; wr = 1'b1;
    @(posedge clk); #1;
    wr = 1'b0;
  endtask

  // Selects bank fa/16K through a register write, then writes at fa's low 14 bits.
  task automatic flash_cmd(input int fa, input logic [7:0] d);
    rd = 8'hFF;
    wr_cycle(15'h4000, 8'(fa / 16384));
    model_write(fa / 16384, 255);
    wr_cycle(15'(fa % 16384), d);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_prg0"}, 32'(o0_prg), 32'(exp_prg(0, m0_bank, int'(a))));
    chk({tag, "_prg1"}, 32'(o1_prg), 32'(exp_prg(1, m1_bank, int'(a))));
    chk({tag, "_chr0"}, 32'(o0_chr), 32'(m0_chr * 8192 + int'(chr)));
    chk({tag, "_chr1"}, 32'(o1_chr), 32'(m1_chr * 8192 + int'(chr)));
    chk({tag, "_ram0"}, 32'(o0_ram), 32'(int'(ram)));
    chk({tag, "_nt0"},  32'(o0_nt),  32'(exp_nt(m0_nt, hw_one, hw_layout)));
    chk({tag, "_nt1"},  32'(o1_nt),  32'(exp_nt(m1_nt, hw_one, hw_layout)));
  endtask

  initial begin
    int n, p0, e0, d, r;
    model_reset();

    // reset state
    a = 15'h4123; hw_layout = 1'b1; hw_one = 1'b0; #1;
    chk("rst_prg_hi", 32'(o0_prg), 32'h7C123);
    chk("rst_nt", 32'(o0_nt), 32'(NAMETABLE_LAYOUT_VERTICAL));
    chk("rst_busy", 32'(o0_busy), 32'h0);
    a = 15'h0123; #1;
    chk("rst_prg_lo", 32'(o0_prg), 32'h00123);
    check_all("rst");
    #3 rst = 1'b0;
    @(posedge clk); #1;

    // bank write 0xE5
    rd = 8'hFF;
    wr_cycle(15'h4000, 8'hE5);
    model_write(8'hE5, 8'hFF);
    a = 15'h0010; chr = 13'h0100; hw_one = 1'b1; #1;
    chk("e5_prg", 32'(o0_prg), 32'h14010);
    chk("e5_chr", 32'(o0_chr), 32'h06100);
    chk("e5_nt", 32'(o0_nt), 32'(NAMETABLE_LAYOUT_SINGLE_SCREEN_UPPER));
    check_all("e5");

    // bus conflicts and fixed-first on dut1
    rd = 8'h03;
    wr_cycle(15'h4000, 8'hFF);
    model_write(8'hFF, 8'h03);
    rd = 8'hFF;
    a = 15'h4010; #1;
    chk("bc_prg_hi", 32'(o1_prg), 32'h0C010);
    a = 15'h0010; #1;
    chk("bc_prg_lo", 32'(o1_prg), 32'h00010);
    check_all("bc");

    // randomized bank writes and lookups
    for (int i = 0; i < 30; i++) begin
      d = int'($urandom_range(0, 255));
      r = int'($urandom_range(0, 255));
      rd = 8'(r);
      wr_cycle(15'h4000 | 15'($urandom_range(0, 16383)), 8'(d));
      rd = 8'hFF;
      model_write(d, r);
      a = 15'($urandom); chr = 13'($urandom); ram = 13'($urandom);
      hw_one = 1'($urandom); hw_layout = 1'($urandom); #1;
      check_all("rnd");
    end

    // byte program
    p0 = prog_seen;
    flash_cmd(32'h5555, 8'hAA);
    flash_cmd(32'h2AAA, 8'h55);
    flash_cmd(32'h5555, 8'hA0);
    flash_cmd(32'h08123, 8'h5A);
    chk("prog_pulse", 32'(o0_prog), 32'h1);
    chk("prog_addr", 32'(o0_faddr), 32'h08123);
    chk("prog_data", 32'(o0_fdata), 32'h5A);
    n = 0;
    while (o0_busy && n < 100) begin
      if (n == 3) wr_cycle(15'h0001, 8'h77);
      else begin @(posedge clk); #1; end
      n++;
    end
    chk("prog_busy_cycles", 32'(n), 32'd16);
    chk("prog_pulse_count", 32'(prog_seen - p0), 32'd1);
    chk("prog_data_hold", 32'(o0_fdata), 32'h5A);
    chk("prog_addr_hold", 32'(o0_faddr), 32'h08123);

    // wrong second byte aborts the sequence
    p0 = prog_seen;
    flash_cmd(32'h5555, 8'hAA);
    flash_cmd(32'h2AAA, 8'h12);
    flash_cmd(32'h2AAA, 8'h55);
    flash_cmd(32'h5555, 8'hA0);
    flash_cmd(32'h08000, 8'h11);
    idle_cycles(2);
    chk("abort_c1_pulses", 32'(prog_seen - p0), 32'd0);
    chk("abort_c1_busy", 32'(o0_busy), 32'h0);
    chk("abort_c1_data", 32'(o0_fdata), 32'h5A);

    // sector erase
    e0 = erase_seen;
    flash_cmd(32'h5555, 8'hAA);
    flash_cmd(32'h2AAA, 8'h55);
    flash_cmd(32'h5555, 8'h80);
    flash_cmd(32'h5555, 8'hAA);
    flash_cmd(32'h2AAA, 8'h55);
    flash_cmd(32'h0A123, 8'h30);
    chk("erase_pulse", 32'(o0_erase), 32'h1);
    chk("erase_addr", 32'(o0_faddr), 32'h0A000);
    chk("erase_busy", 32'(o0_busy), 32'h1);
    n = 0;
    while (o0_busy && n < 100) begin @(posedge clk); #1; n++; end
    chk("erase_busy_cycles", 32'(n), 32'd16);
    chk("erase_pulse_count", 32'(erase_seen - e0), 32'd1);

    // F0 in E4 returns to idle
    e0 = erase_seen;
    flash_cmd(32'h5555, 8'hAA);
    flash_cmd(32'h2AAA, 8'h55);
    flash_cmd(32'h5555, 8'h80);
    flash_cmd(32'h5555, 8'hAA);
    flash_cmd(32'h5555, 8'hF0);
    flash_cmd(32'h2AAA, 8'h55);
    flash_cmd(32'h0A123, 8'h30);
    idle_cycles(2);
    chk("abort_e4_pulses", 32'(erase_seen - e0), 32'd0);
    chk("abort_e4_busy", 32'(o0_busy), 32'h0);

    // reset mid-busy
    flash_cmd(32'h5555, 8'hAA);
    flash_cmd(32'h2AAA, 8'h55);
    flash_cmd(32'h5555, 8'hA0);
    flash_cmd(32'h08123, 8'h3C);
    idle_cycles(2);
    chk("pre_rst_busy", 32'(o0_busy), 32'h1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("rst_mid_busy", 32'(o0_busy), 32'h0);
    chk("rst_mid_addr", 32'(o0_faddr), 32'h0);
    chk("rst_mid_data", 32'(o0_fdata), 32'h0);
    a = 15'h0123; #1;
    chk("rst_mid_bank", 32'(o0_prg), 32'h00123);
    check_all("rst_mid");
    rst = 1'b0;
    @(posedge clk); #1;
    idle_cycles(2);
    chk("post_rst_busy", 32'(o0_busy), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
